cache_bus_arbiter: RTL and testbench

CACHE_BUS_ARBITER -- requirements
Module: cache_bus_arbiter

---
 rtl/cache_bus_arbiter_pkg.sv | 27 ++
 rtl/cache_bus_arbiter.sv | 110 +++++++++++
 tb/tb_cache_bus_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_bus_arbiter_pkg.sv
// Shared LSU cache-bus types: one request/response pair used by both L1 caches and the
// downstream bus port.
package cache_bus_arbiter_pkg;

   localparam int BUS_AW = 32;
   localparam int BUS_DW = 32;

   typedef struct packed {
      logic              valid;
      logic              wr;
      logic [1:0]        size;
      logic              cached;
      logic [BUS_AW-1:0] addr;
      logic              data_ok;      // write beat valid
      logic              data_last;    // final write beat
      logic [3:0]        data_strobe;
      logic [BUS_DW-1:0] w_data;
   } cache_bus_req_t;

   typedef struct packed {
      logic              ready;        // address phase accepted
      logic              data_ok;      // data beat valid
      logic              data_last;    // final beat of the transaction
      logic [BUS_DW-1:0] r_data;
   } cache_bus_resp_t;

endpackage

// File: rtl/cache_bus_arbiter.sv
// Two-master arbiter sharing one downstream cache bus between icache and dcache.
// Grants are taken from IDLE only; the owner keeps the bus until its final data beat.
module cache_bus_arbiter
   import cache_bus_arbiter_pkg::*;
#(
   parameter logic DCACHE_PRIORITY = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  cache_bus_req_t  ic_req_i,
   output cache_bus_resp_t ic_resp_o,
   output logic            ic_busy_o,
   input  cache_bus_req_t  dc_req_i,
   output cache_bus_resp_t dc_resp_o,
   output logic            dc_busy_o,
   output cache_bus_req_t  bus_req_o,
   input  cache_bus_resp_t bus_resp_i
);

   typedef enum logic [4:0] {
      IDLE   = 5'b00001,
      ADDR_I = 5'b00010,
      DATA_I = 5'b00100,
      ADDR_D = 5'b01000,
      DATA_D = 5'b10000
   } state_e;

   state_e state_q, state_d;
   logic   last_dc_q, last_dc_d;   // 1 = dcache won the most recent grant

   // Only called when at least one port is valid; a tie goes to the fixed winner or
   // to whichever port lost the previous grant.
   function automatic logic grant_dcache(input logic ic_v, input logic dc_v,
                                         input logic last_dc);
      if (ic_v && dc_v) begin
         return DCACHE_PRIORITY ? 1'b1 : !last_dc;
      end
      return dc_v;
   endfunction

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // pre-edge value of its peers regardless of process ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         last_dc_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_dc_q <= last_dc_d;
      end
   end

   // NOTE: every variable driven here gets a default first, so no path leaves a
   // value unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      last_dc_d = last_dc_q;
      case (state_q)
         IDLE: begin
            if (ic_req_i.valid || dc_req_i.valid) begin
               if (grant_dcache(ic_req_i.valid, dc_req_i.valid, last_dc_q)) begin
                  state_d   = ADDR_D;
                  last_dc_d = 1'b1;
               end else begin
                  state_d   = ADDR_I;
                  last_dc_d = 1'b0;
               end
            end
         end
         ADDR_I: begin
            if (!ic_req_i.valid)       state_d = IDLE;
            else if (bus_resp_i.ready) state_d = DATA_I;
         end
         DATA_I: begin
            if (bus_resp_i.data_ok && bus_resp_i.data_last) state_d = IDLE;
         end
         ADDR_D: begin
            if (!dc_req_i.valid)       state_d = IDLE;
            else if (bus_resp_i.ready) state_d = DATA_D;
         end
         DATA_D: begin
            if (bus_resp_i.data_ok && bus_resp_i.data_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode the registered owner only; a new request never reaches the bus
   // in the cycle it first appears.
   logic own_ic, own_dc;
   assign own_ic = (state_q == ADDR_I) || (state_q == DATA_I);
   assign own_dc = (state_q == ADDR_D) || (state_q == DATA_D);

   always_comb begin
      bus_req_o = '0;
      ic_resp_o = '0;
      dc_resp_o = '0;
      if (own_ic) begin
         bus_req_o = ic_req_i;
         ic_resp_o = bus_resp_i;
      end else if (own_dc) begin
         bus_req_o = dc_req_i;
         dc_resp_o = bus_resp_i;
      end
   end

   assign ic_busy_o = own_dc;
   assign dc_busy_o = own_ic;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Bench for cache_bus_arbiter: a round-robin instance (index 0) and a dcache-priority
// instance (index 1), each checked every cycle against an ownership model.
module tb_cache_bus_arbiter;
   import cache_bus_arbiter_pkg::*;

   localparam int NONE = 0;
   localparam int IC   = 1;
   localparam int DC   = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   cache_bus_req_t  ic_req  [2];
   cache_bus_req_t  dc_req  [2];
   cache_bus_req_t  bus_req [2];
   cache_bus_resp_t ic_resp [2];
   cache_bus_resp_t dc_resp [2];
   cache_bus_resp_t bus_resp[2];
   logic            ic_busy [2];
   logic            dc_busy [2];

   cache_bus_arbiter #(.DCACHE_PRIORITY(1'b0)) dut_rr (
      .clk(clk), .rst_n(rst_n),
      .ic_req_i(ic_req[0]), .ic_resp_o(ic_resp[0]), .ic_busy_o(ic_busy[0]),
      .dc_req_i(dc_req[0]), .dc_resp_o(dc_resp[0]), .dc_busy_o(dc_busy[0]),
      .bus_req_o(bus_req[0]), .bus_resp_i(bus_resp[0])
   );

   cache_bus_arbiter #(.DCACHE_PRIORITY(1'b1)) dut_pri (
      .clk(clk), .rst_n(rst_n),
      .ic_req_i(ic_req[1]), .ic_resp_o(ic_resp[1]), .ic_busy_o(ic_busy[1]),
      .dc_req_i(dc_req[1]), .dc_resp_o(dc_resp[1]), .dc_busy_o(dc_busy[1]),
      .bus_req_o(bus_req[1]), .bus_resp_i(bus_resp[1])
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Model: who owns each bus, whether its address phase is done, who won last.
   int m_own     [2];
   bit m_data    [2];
   bit m_last_dc [2];
   bit model_live = 1'b0;

   function automatic int pick_winner(input int k);
      if (ic_req[k].valid && dc_req[k].valid) begin
         if (k == 1) return DC;
         return m_last_dc[k] ? IC : DC;
      end
      if (ic_req[k].valid) return IC;
      if (dc_req[k].valid) return DC;
      return NONE;
   endfunction

   function automatic cache_bus_req_t owner_req(input int k);
      if (m_own[k] == IC) return ic_req[k];
      if (m_own[k] == DC) return dc_req[k];
      return '0;
   endfunction

   function automatic cache_bus_resp_t exp_resp(input int k, input int port);
      if (m_own[k] == port) return bus_resp[k];
      return '0;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) model_live <= 1'b1;
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            m_own[k]     <= NONE;
            m_data[k]    <= 1'b0;
            m_last_dc[k] <= 1'b0;
         end else if (m_own[k] == NONE) begin
            if (pick_winner(k) != NONE) begin
               m_own[k]     <= pick_winner(k);
               m_data[k]    <= 1'b0;
               m_last_dc[k] <= (pick_winner(k) == DC);
            end
         end else if (!m_data[k]) begin
            if (!owner_req(k).valid)    m_own[k]  <= NONE;
            else if (bus_resp[k].ready) m_data[k] <= 1'b1;
         end else if (bus_resp[k].data_ok && bus_resp[k].data_last) begin
            m_own[k]  <= NONE;
            m_data[k] <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (model_live) begin
         for (int k = 0; k < 2; k++) begin
            check($sformatf("dut%0d bus_req", k), 128'(bus_req[k]), 128'(owner_req(k)));
            check($sformatf("dut%0d ic_resp", k), 128'(ic_resp[k]), 128'(exp_resp(k, IC)));
            check($sformatf("dut%0d dc_resp", k), 128'(dc_resp[k]), 128'(exp_resp(k, DC)));
            check($sformatf("dut%0d busy{ic,dc}", k), 128'({ic_busy[k], dc_busy[k]}),
                  128'({m_own[k] == DC, m_own[k] == IC}));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      for (int k = 0; k < 2; k++) begin
         ic_req[k]   = '0;
         dc_req[k]   = '0;
         bus_resp[k] = '0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      step();
      rst_n = 1'b1;
   endtask

   int busy_cycles;
   int beats;
   int dc_wins;
   cache_bus_req_t wr_req;

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      step();
      step();
      rst_n = 1'b1;
      mid();
      check("reset bus valid rr", 128'(bus_req[0].valid), 128'(0));
      check("reset busy pri", 128'({ic_busy[1], dc_busy[1]}), 128'(0));
      step();

      // Icache 4-beat refill with ready in the second cycle of the address phase.
      ic_req[0].valid  = 1'b1;
      ic_req[0].cached = 1'b1;
      ic_req[0].addr   = 32'h1C00_0010;
      busy_cycles = 0;
      beats = 0;
      step();
      mid();
      check("refill addr", 128'(bus_req[0].addr), 128'(32'h1C00_0010));
      check("refill addr valid", 128'(bus_req[0].valid), 128'(1));
      busy_cycles += int'(dc_busy[0]);
      step();
      bus_resp[0].ready = 1'b1;
      mid();
      busy_cycles += int'(dc_busy[0]);
      step();
      for (int b = 0; b < 4; b++) begin
         ic_req[0].valid       = 1'b0;
         bus_resp[0]           = '0;
         bus_resp[0].data_ok   = 1'b1;
         bus_resp[0].data_last = (b == 3);
         bus_resp[0].r_data    = 32'hA0 + b;
         mid();
         if (ic_resp[0].data_ok) beats++;
         busy_cycles += int'(dc_busy[0]);
         check($sformatf("refill beat %0d data", b), 128'(ic_resp[0].r_data), 128'(32'hA0 + b));
         step();
      end
      bus_resp[0] = '0;
      mid();
      check("refill beats", 128'(beats), 128'(4));
      check("refill dc_busy cycles", 128'(busy_cycles), 128'(6));
      check("refill back to idle", 128'({dc_busy[0], bus_req[0].valid}), 128'(0));
      step();

      // Tie after reset, round-robin: dcache first, icache two cycles after its last beat.
      do_reset();
      ic_req[0].valid = 1'b1;
      ic_req[0].addr  = 32'h1C00_0100;
      dc_req[0].valid = 1'b1;
      dc_req[0].addr  = 32'h8000_0040;
      step();
      bus_resp[0].ready = 1'b1;
      mid();
      check("tie rr first addr", 128'(bus_req[0].addr), 128'(32'h8000_0040));
      check("tie rr ic_busy", 128'(ic_busy[0]), 128'(1));
      step();
      dc_req[0].valid       = 1'b0;
      bus_resp[0]           = '0;
      bus_resp[0].data_ok   = 1'b1;
      bus_resp[0].data_last = 1'b1;
      step();
      bus_resp[0] = '0;
      mid();
      check("tie rr idle gap", 128'(bus_req[0].valid), 128'(0));
      step();
      bus_resp[0].ready = 1'b1;
      mid();
      check("tie rr second addr", 128'(bus_req[0].addr), 128'(32'h1C00_0100));
      check("tie rr dc_busy", 128'(dc_busy[0]), 128'(1));
      step();
      ic_req[0].valid       = 1'b0;
      bus_resp[0]           = '0;
      bus_resp[0].data_ok   = 1'b1;
      bus_resp[0].data_last = 1'b1;
      step();
      clear_inputs();

      // Fixed dcache priority: three ties, dcache wins each one.
      dc_wins = 0;
      for (int rep = 0; rep < 3; rep++) begin
         ic_req[1].valid = 1'b1;
         ic_req[1].addr  = 32'h1C00_0200 + 32'(rep);
         dc_req[1].valid = 1'b1;
         dc_req[1].addr  = 32'h8000_0200 + 32'(rep);
         step();
         bus_resp[1].ready = 1'b1;
         mid();
         if (bus_req[1].addr == 32'h8000_0200 + 32'(rep) && ic_busy[1]) dc_wins++;
         step();
         ic_req[1].valid       = 1'b0;
         dc_req[1].valid       = 1'b0;
         bus_resp[1]           = '0;
         bus_resp[1].data_ok   = 1'b1;
         bus_resp[1].data_last = 1'b1;
         step();
         bus_resp[1] = '0;
      end
      check("priority dcache wins", 128'(dc_wins), 128'(3));
      step();

      // Dcache single write; a data_ok during the address phase is ignored.
      wr_req             = '0;
      wr_req.valid       = 1'b1;
      wr_req.wr          = 1'b1;
      wr_req.size        = 2'd2;
      wr_req.addr        = 32'h8000_1000;
      wr_req.data_ok     = 1'b1;
      wr_req.data_last   = 1'b1;
      wr_req.data_strobe = 4'b1111;
      wr_req.w_data      = 32'hDEAD_BEEF;
      dc_req[0] = wr_req;
      step();
      bus_resp[0].data_ok   = 1'b1;
      bus_resp[0].data_last = 1'b1;
      mid();
      check("write bus_req fields", 128'(bus_req[0]), 128'(wr_req));
      check("write ic_resp zero", 128'(ic_resp[0]), 128'(0));
      step();
      bus_resp[0]       = '0;
      bus_resp[0].ready = 1'b1;
      mid();
      check("write stray data_ok kept addr", 128'(ic_busy[0]), 128'(1));
      check("write w_data", 128'(bus_req[0].w_data), 128'(32'hDEAD_BEEF));
      check("write strobe", 128'(bus_req[0].data_strobe), 128'(4'b1111));
      step();
      dc_req[0].valid       = 1'b0;
      bus_resp[0]           = '0;
      bus_resp[0].data_ok   = 1'b1;
      bus_resp[0].data_last = 1'b1;
      mid();
      check("write data ic_resp zero", 128'(ic_resp[0]), 128'(0));
      step();
      clear_inputs();

      // Icache abandons in its address phase; it still counts as the last winner.
      ic_req[0].valid = 1'b1;
      ic_req[0].addr  = 32'h1C00_0300;
      step();
      ic_req[0].valid = 1'b0;
      step();
      mid();
      check("abandon bus valid", 128'(bus_req[0].valid), 128'(0));
      check("abandon dc_busy", 128'(dc_busy[0]), 128'(0));
      ic_req[0].valid = 1'b1;
      dc_req[0].valid = 1'b1;
      dc_req[0].addr  = 32'h8000_0300;
      step();
      mid();
      check("tie after ic abandon -> dcache", 128'(ic_busy[0]), 128'(1));
      ic_req[0].valid = 1'b0;
      dc_req[0].valid = 1'b0;
      step();
      clear_inputs();
      step();

      // Reset during dcache beat 2, then stray data beats.
      dc_req[0].valid = 1'b1;
      dc_req[0].addr  = 32'h8000_0400;
      step();
      bus_resp[0].ready = 1'b1;
      step();
      dc_req[0].valid     = 1'b0;
      bus_resp[0]         = '0;
      bus_resp[0].data_ok = 1'b1;
      bus_resp[0].r_data  = 32'h1111_0001;
      step();
      bus_resp[0].r_data = 32'h1111_0002;
      rst_n = 1'b0;
      mid();
      check("beat2 before reset", 128'(dc_resp[0].r_data), 128'(32'h1111_0002));
      step();
      rst_n = 1'b1;
      bus_resp[0].data_last = 1'b1;
      mid();
      check("post-reset bus_req zero", 128'(bus_req[0]), 128'(0));
      check("post-reset dc_resp zero", 128'(dc_resp[0]), 128'(0));
      check("post-reset busy zero", 128'({ic_busy[0], dc_busy[0]}), 128'(0));
      step();
      mid();
      check("stray data_ok ignored", 128'({ic_busy[0], bus_req[0].valid}), 128'(0));
      step();
      clear_inputs();
      step();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
